// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction loader.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package loader_pkg;

  localparam int INSTR_W_DEF = 15;
  localparam int ADDR_W_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LO,
    S_HI,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/instruction_loader.sv
// Streams COUNT,(LO,HI)*COUNT,CHK bytes into instruction memory and verifies an XOR checksum.
// Latency: 3 cycles per word (LO, HI, WRITE) at full input rate; the DONE pulse follows CHECK by one cycle.
// Backpressure: in_ready is low in IDLE, WRITE and DONE; upstream must hold its byte until in_ready.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_data,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [7:0]           chk_q, chk_d;
  logic [7:0]           lo_q, lo_d;
  logic [ADDR_W-1:0]    im_addr_q, im_addr_d;
  logic [INSTR_W-1:0]   im_data_q, im_data_d;
  logic                 err_q, err_d;
  logic [15:0]          word;
  logic                 xfer;

  // Receiving states accept a byte; everything else stalls the stream.
  assign in_ready  = (state_q == S_LEN) || (state_q == S_LO) ||
                     (state_q == S_HI)  || (state_q == S_CHECK);
  assign xfer      = in_valid && in_ready;
  assign im_we     = (state_q == S_WRITE);
  assign cpu_hold  = (state_q != S_IDLE);
  assign load_done = (state_q == S_DONE);
  assign load_err  = err_q;
  assign im_addr   = im_addr_q;
  assign im_data   = im_data_q;
  assign word      = {in_data, lo_q};

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      chk_q     <= '0;
      lo_q      <= '0;
      im_addr_q <= '0;
      im_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      chk_q     <= chk_d;
      lo_q      <= lo_d;
      im_addr_q <= im_addr_d;
      im_data_q <= im_data_d;
      err_q     <= err_d;
    end
  end

  // Next-state and datapath updates; memory port registers are loaded on the HI
  // transfer so they are valid during WRITE and hold afterwards.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    chk_d     = chk_q;
    lo_d      = lo_q;
    im_addr_d = im_addr_q;
    im_data_d = im_data_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          err_d   = 1'b0;
          chk_d   = '0;
          addr_d  = '0;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer) begin
          // A count of zero wraps to a full 2^ADDR_W word load via the decrement.
          cnt_d   = ADDR_W'(in_data);
          chk_d   = chk_q ^ in_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          chk_d   = chk_q ^ in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          chk_d     = chk_q ^ in_data;
          im_addr_d = addr_q;
          im_data_d = word[INSTR_W-1:0];
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == ADDR_W'(1)) ? S_CHECK : S_LO;
      end
      S_CHECK: begin
        if (xfer) begin
          err_d   = (in_data != chk_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: stimulus pushes expected writes and done flags,
// a negedge monitor pops and compares whenever the DUT writes memory or pulses load_done.
// Directed streams cover checksum pass/fail, truncation with stalls, full wrap and reset abort.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [14:0] im_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  typedef struct {
    logic [7:0]  addr;
    logic [14:0] data;
  } wr_t;

  wr_t  wq[$];
  logic dq[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] lo_b [256];
  logic [7:0] hi_b [256];

  always #5 clk = ~clk;

  instruction_loader #(.INSTR_W(15), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write and every done pulse must match the scoreboard.
  initial begin
    wr_t e;
    logic de;
    forever begin
      @(negedge clk);
      if (im_we === 1'b1) begin
        check("wr_in_ready_low", in_ready, 0);
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", im_addr, im_data);
        end else begin
          e = wq.pop_front();
          check("wr_addr", im_addr, e.addr);
          check("wr_data", im_data, e.data);
        end
      end
      if (load_done === 1'b1) begin
        check("done_cpu_hold", cpu_hold, 1);
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: load_done pulsed, none expected");
        end else begin
          de = dq.pop_front();
          check("done_load_err", load_err, de);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  // Present a byte and hold it until accepted; returns #1 after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready %0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cpu_hold !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: cpu_hold %0b required 0", cpu_hold);
    end
  endtask

  // Load n words from lo_b/hi_b; bad_chk sends 0x00 instead of the true checksum.
  task automatic load_prog(input int n, input logic bad_chk);
    logic [7:0] cnt, chk, sent;
    wr_t w;
    cnt = 8'(n);
    chk = cnt;
    for (int i = 0; i < n; i++) begin
      chk ^= lo_b[i] ^ hi_b[i];
      w.addr = 8'(i);
      w.data = {hi_b[i][6:0], lo_b[i]};
      wq.push_back(w);
    end
    sent = bad_chk ? 8'h00 : chk;
    dq.push_back(sent != chk);
    pulse_start();
    send_byte(cnt);
    check("hold_after_len", cpu_hold, 1);
    for (int i = 0; i < n; i++) begin
      send_byte(lo_b[i]);
      send_byte(hi_b[i]);
    end
    send_byte(sent);
    wait_idle();
  endtask

  initial begin
    wr_t w;
    reset = 1'b1; load_start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_im_we", im_we, 0);
    check("rst_im_addr", im_addr, 0);
    check("rst_im_data", im_data, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    reset = 1'b0;

    // Basic load: words 0x0064 and 0x010A, CHK 0x6D.
    lo_b[0] = 8'h64; hi_b[0] = 8'h00;
    lo_b[1] = 8'h0A; hi_b[1] = 8'h01;
    load_prog(2, 1'b0);
    check("basic_err", load_err, 0);

    // Same stream with a wrong checksum: writes still happen, error is sticky.
    load_prog(2, 1'b1);
    repeat (5) @(negedge clk);
    check("err_sticky", load_err, 1);

    // Truncation with a 3-cycle stall between LO and HI.
    w.addr = 8'h00; w.data = 15'h7FFF;
    wq.push_back(w);
    dq.push_back(1'b0);
    pulse_start();
    check("err_cleared", load_err, 0);
    send_byte(8'h01);
    send_byte(8'hFF);
    repeat (3) begin
      @(negedge clk);
      check("gap_in_ready", in_ready, 1);
      check("gap_no_write", im_we, 0);
    end
    send_byte(8'hFF);
    send_byte(8'h01);
    wait_idle();
    check("trunc_err", load_err, 0);

    // Full 256-word load with data = address; XOR of 0..255 is 0.
    for (int i = 0; i < 256; i++) begin
      lo_b[i] = 8'(i);
      hi_b[i] = 8'h00;
    end
    load_prog(256, 1'b0);
    check("wrap_addr", dut.addr_q, 0);
    check("wrap_err", load_err, 0);

    // Reset right after the first WRITE of a 3-word load.
    w.addr = 8'h00; w.data = 15'h1234;
    wq.push_back(w);
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h34);
    send_byte(8'h12);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_in_ready", in_ready, 0);
    check("abort_im_we", im_we, 0);
    check("abort_im_addr", im_addr, 0);
    check("abort_im_data", im_data, 0);
    check("abort_cpu_hold", cpu_hold, 0);
    check("abort_load_done", load_done, 0);
    check("abort_load_err", load_err, 0);
    repeat (5) @(negedge clk);
    check("abort_writes_left", wq.size(), 0);
    check("abort_done_left", dq.size(), 0);

    // load_start during HI is ignored; program words 100 and 200.
    w.addr = 8'h00; w.data = 15'd100; wq.push_back(w);
    w.addr = 8'h01; w.data = 15'd200; wq.push_back(w);
    dq.push_back(1'b0);
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h64);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("ign_hold", cpu_hold, 1);
    send_byte(8'h00);
    send_byte(8'hC8);
    send_byte(8'h00);
    send_byte(8'hAE);
    wait_idle();
    check("ign_err", load_err, 0);

    repeat (5) @(negedge clk);
    check("final_writes_left", wq.size(), 0);
    check("final_done_left", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
